// File: rtl/ip_arp_tx_ctrl.sv
// rtl/ip_arp_tx_ctrl.sv - IPv4 transmit next-hop MAC resolver and packet gate
// Resolves the destination MAC of an outgoing IP packet (broadcast, multicast, cache or ARP) and forwards or drops it.
module ip_arp_tx_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH/8,
  parameter int ARP_TIMEOUT    = 4096,
  parameter int CACHE_ENABLE   = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_ip_hdr_valid,
  output logic                      s_ip_hdr_ready,
  input  logic [5:0]                s_ip_dscp,
  input  logic [1:0]                s_ip_ecn,
  input  logic [15:0]               s_ip_length,
  input  logic [7:0]                s_ip_ttl,
  input  logic [7:0]                s_ip_protocol,
  input  logic [31:0]               s_ip_source_ip,
  input  logic [31:0]               s_ip_dest_ip,
  input  logic [DATA_WIDTH-1:0]     s_ip_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_ip_payload_axis_tkeep,
  input  logic                      s_ip_payload_axis_tvalid,
  output logic                      s_ip_payload_axis_tready,
  input  logic                      s_ip_payload_axis_tlast,
  input  logic                      s_ip_payload_axis_tuser,
  output logic                      m_ip_hdr_valid,
  input  logic                      m_ip_hdr_ready,
  output logic [47:0]               m_eth_dest_mac,
  output logic [47:0]               m_eth_src_mac,
  output logic [15:0]               m_eth_type,
  output logic [5:0]                m_ip_dscp,
  output logic [1:0]                m_ip_ecn,
  output logic [15:0]               m_ip_length,
  output logic [7:0]                m_ip_ttl,
  output logic [7:0]                m_ip_protocol,
  output logic [31:0]               m_ip_source_ip,
  output logic [31:0]               m_ip_dest_ip,
  output logic [DATA_WIDTH-1:0]     m_ip_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]     m_ip_payload_axis_tkeep,
  output logic                      m_ip_payload_axis_tvalid,
  input  logic                      m_ip_payload_axis_tready,
  output logic                      m_ip_payload_axis_tlast,
  output logic                      m_ip_payload_axis_tuser,
  output logic                      arp_request_valid,
  input  logic                      arp_request_ready,
  output logic [31:0]               arp_request_ip,
  input  logic                      arp_response_valid,
  output logic                      arp_response_ready,
  input  logic                      arp_response_error,
  input  logic [47:0]               arp_response_mac,
  input  logic [47:0]               local_mac,
  input  logic [31:0]               local_ip,
  input  logic [31:0]               subnet_mask,
  input  logic                      cache_flush,
  output logic                      busy,
  output logic                      tx_error_arp_failed,
  output logic                      tx_error_arp_timeout,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int TW = (ARP_TIMEOUT > 1) ? $clog2(ARP_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_ARP_QUERY, S_HDR_OUT, S_PAYLOAD
  } state_t;

  state_t                    state_q, state_d;
  logic                      hdr_ready_q, hdr_ready_d;
  logic [5:0]                dscp_q, dscp_d;
  logic [1:0]                ecn_q, ecn_d;
  logic [15:0]               length_q, length_d;
  logic [7:0]                ttl_q, ttl_d;
  logic [7:0]                protocol_q, protocol_d;
  logic [31:0]               src_ip_q, src_ip_d;
  logic [31:0]               dest_ip_q, dest_ip_d;
  logic [47:0]               dest_mac_q, dest_mac_d;
  logic [47:0]               src_mac_q, src_mac_d;
  logic                      hdr_valid_q, hdr_valid_d;
  logic                      arp_req_valid_q, arp_req_valid_d;
  logic                      arp_resp_ready_q, arp_resp_ready_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      drop_q, drop_d;
  logic                      arp_failed_q, arp_failed_d;
  logic                      arp_timeout_q, arp_timeout_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      cache_valid_q, cache_valid_d;
  logic [31:0]               cache_ip_q, cache_ip_d;
  logic [47:0]               cache_mac_q, cache_mac_d;

  logic is_bcast, is_mcast, is_hit, fwd, s_last_hs;

  always_comb begin
    state_d          = state_q;
    hdr_ready_d      = 1'b0;
    dscp_d           = dscp_q;
    ecn_d            = ecn_q;
    length_d         = length_q;
    ttl_d            = ttl_q;
    protocol_d       = protocol_q;
    src_ip_d         = src_ip_q;
    dest_ip_d        = dest_ip_q;
    dest_mac_d       = dest_mac_q;
    src_mac_d        = src_mac_q;
    hdr_valid_d      = hdr_valid_q;
    arp_req_valid_d  = arp_req_valid_q;
    arp_resp_ready_d = arp_resp_ready_q;
    timer_d          = timer_q;
    drop_d           = drop_q;
    arp_failed_d     = 1'b0;
    arp_timeout_d    = 1'b0;
    drop_cnt_d       = drop_cnt_q;
    cache_valid_d    = cache_valid_q;
    cache_ip_d       = cache_ip_q;
    cache_mac_d      = cache_mac_q;

    is_bcast = (dest_ip_q == 32'hFFFF_FFFF) || (dest_ip_q == (local_ip | ~subnet_mask));
    is_mcast = (dest_ip_q[31:28] == 4'hE);
    is_hit   = (CACHE_ENABLE != 0) && cache_valid_q && (dest_ip_q == cache_ip_q);

    fwd       = (state_q == S_PAYLOAD) && !drop_q;
    s_ip_payload_axis_tready = (state_q == S_PAYLOAD) && (drop_q || m_ip_payload_axis_tready);
    m_ip_payload_axis_tvalid = fwd && s_ip_payload_axis_tvalid;
    m_ip_payload_axis_tdata  = fwd ? s_ip_payload_axis_tdata : '0;
    m_ip_payload_axis_tkeep  = fwd ? s_ip_payload_axis_tkeep : '0;
    m_ip_payload_axis_tlast  = fwd && s_ip_payload_axis_tlast;
    m_ip_payload_axis_tuser  = fwd && s_ip_payload_axis_tuser;
    s_last_hs = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready && s_ip_payload_axis_tlast;

    case (state_q)
      S_IDLE: begin
        hdr_ready_d = 1'b1;
        if (s_ip_hdr_valid && hdr_ready_q) begin
          hdr_ready_d = 1'b0;
          dscp_d      = s_ip_dscp;
          ecn_d       = s_ip_ecn;
          length_d    = s_ip_length;
          ttl_d       = s_ip_ttl;
          protocol_d  = s_ip_protocol;
          src_ip_d    = s_ip_source_ip;
          dest_ip_d   = s_ip_dest_ip;
          state_d     = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        src_mac_d = local_mac;
        drop_d    = 1'b0;
        if (is_bcast || is_mcast || is_hit) begin
          if (is_bcast)      dest_mac_d = 48'hFFFF_FFFF_FFFF;
          else if (is_mcast) dest_mac_d = {24'h01005E, 1'b0, dest_ip_q[22:0]};
          else               dest_mac_d = cache_mac_q;
          hdr_valid_d = 1'b1;
          state_d     = S_HDR_OUT;
        end else begin
          arp_req_valid_d  = 1'b1;
          arp_resp_ready_d = 1'b1;
          timer_d          = TW'(ARP_TIMEOUT - 1);
          state_d          = S_ARP_QUERY;
        end
      end
      S_ARP_QUERY: begin
        timer_d = timer_q - TW'(1);
        if (arp_req_valid_q && arp_request_ready) arp_req_valid_d = 1'b0;
        // A response in the expiry cycle still takes priority over the timeout.
        if (arp_response_valid) begin
          arp_req_valid_d  = 1'b0;
          arp_resp_ready_d = 1'b0;
          if (!arp_response_error) begin
            dest_mac_d  = arp_response_mac;
            hdr_valid_d = 1'b1;
            state_d     = S_HDR_OUT;
            if (CACHE_ENABLE != 0) begin
              cache_valid_d = 1'b1;
              cache_ip_d    = dest_ip_q;
              cache_mac_d   = arp_response_mac;
            end
          end else begin
            arp_failed_d = 1'b1;
            drop_d       = 1'b1;
            state_d      = S_PAYLOAD;
          end
        end else if (timer_q == '0) begin
          arp_timeout_d    = 1'b1;
          arp_req_valid_d  = 1'b0;
          arp_resp_ready_d = 1'b0;
          drop_d           = 1'b1;
          state_d          = S_PAYLOAD;
        end
      end
      S_HDR_OUT: begin
        if (m_ip_hdr_ready) begin
          hdr_valid_d = 1'b0;
          drop_d      = 1'b0;
          state_d     = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (s_last_hs) begin
          state_d = S_IDLE;
          if (drop_q && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cache_flush) cache_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      hdr_ready_q      <= 1'b0;
      dscp_q           <= '0;
      ecn_q            <= '0;
      length_q         <= '0;
      ttl_q            <= '0;
      protocol_q       <= '0;
      src_ip_q         <= '0;
      dest_ip_q        <= '0;
      dest_mac_q       <= '0;
      src_mac_q        <= '0;
      hdr_valid_q      <= 1'b0;
      arp_req_valid_q  <= 1'b0;
      arp_resp_ready_q <= 1'b0;
      timer_q          <= '0;
      drop_q           <= 1'b0;
      arp_failed_q     <= 1'b0;
      arp_timeout_q    <= 1'b0;
      drop_cnt_q       <= '0;
      cache_valid_q    <= 1'b0;
      cache_ip_q       <= '0;
      cache_mac_q      <= '0;
    end else begin
      state_q          <= state_d;
      hdr_ready_q      <= hdr_ready_d;
      dscp_q           <= dscp_d;
      ecn_q            <= ecn_d;
      length_q         <= length_d;
      ttl_q            <= ttl_d;
      protocol_q       <= protocol_d;
      src_ip_q         <= src_ip_d;
      dest_ip_q        <= dest_ip_d;
      dest_mac_q       <= dest_mac_d;
      src_mac_q        <= src_mac_d;
      hdr_valid_q      <= hdr_valid_d;
      arp_req_valid_q  <= arp_req_valid_d;
      arp_resp_ready_q <= arp_resp_ready_d;
      timer_q          <= timer_d;
      drop_q           <= drop_d;
      arp_failed_q     <= arp_failed_d;
      arp_timeout_q    <= arp_timeout_d;
      drop_cnt_q       <= drop_cnt_d;
      cache_valid_q    <= cache_valid_d;
      cache_ip_q       <= cache_ip_d;
      cache_mac_q      <= cache_mac_d;
    end
  end

  assign s_ip_hdr_ready       = hdr_ready_q;
  assign m_ip_hdr_valid       = hdr_valid_q;
  assign m_eth_dest_mac       = dest_mac_q;
  assign m_eth_src_mac        = src_mac_q;
  assign m_eth_type           = 16'h0800;
  assign m_ip_dscp            = dscp_q;
  assign m_ip_ecn             = ecn_q;
  assign m_ip_length          = length_q;
  assign m_ip_ttl             = ttl_q;
  assign m_ip_protocol        = protocol_q;
  assign m_ip_source_ip       = src_ip_q;
  assign m_ip_dest_ip         = dest_ip_q;
  assign arp_request_valid    = arp_req_valid_q;
  assign arp_request_ip       = dest_ip_q;
  assign arp_response_ready   = arp_resp_ready_q;
  assign busy                 = (state_q != S_IDLE);
  assign tx_error_arp_failed  = arp_failed_q;
  assign tx_error_arp_timeout = arp_timeout_q;
  assign drop_count           = drop_cnt_q;

endmodule

// File: tb/tb_ip_arp_tx_ctrl.sv
// tb/tb_ip_arp_tx_ctrl.sv - directed table-driven bench for ip_arp_tx_ctrl
module tb_ip_arp_tx_ctrl;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam logic [31:0] LIP  = 32'hC0A8_0180;
  localparam logic [31:0] MSK  = 32'hFFFF_FF00;
  localparam logic [47:0] LMAC = 48'h0200_0000_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_ip_hdr_valid, s_ip_hdr_ready;
  logic [5:0]    s_ip_dscp;
  logic [1:0]    s_ip_ecn;
  logic [15:0]   s_ip_length;
  logic [7:0]    s_ip_ttl, s_ip_protocol;
  logic [31:0]   s_ip_source_ip, s_ip_dest_ip;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic          m_ip_hdr_valid, m_ip_hdr_ready;
  logic [47:0]   m_eth_dest_mac, m_eth_src_mac;
  logic [15:0]   m_eth_type;
  logic [5:0]    m_ip_dscp;
  logic [1:0]    m_ip_ecn;
  logic [15:0]   m_ip_length;
  logic [7:0]    m_ip_ttl, m_ip_protocol;
  logic [31:0]   m_ip_source_ip, m_ip_dest_ip;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic          arp_request_valid, arp_request_ready;
  logic [31:0]   arp_request_ip;
  logic          arp_response_valid, arp_response_ready, arp_response_error;
  logic [47:0]   arp_response_mac;
  logic [47:0]   local_mac;
  logic [31:0]   local_ip, subnet_mask;
  logic          cache_flush, busy, tx_error_arp_failed, tx_error_arp_timeout;
  logic [15:0]   drop_count;

  int tests_run = 0;
  int tests_failed = 0;

  ip_arp_tx_ctrl #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ARP_TIMEOUT(16),
                   .CACHE_ENABLE(1), .DROP_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
    .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
    .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
    .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
    .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
    .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
    .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .local_mac(local_mac), .local_ip(local_ip), .subnet_mask(subnet_mask),
    .cache_flush(cache_flush), .busy(busy),
    .tx_error_arp_failed(tx_error_arp_failed), .tx_error_arp_timeout(tx_error_arp_timeout),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dest;
    logic [31:0] lip;
    logic [31:0] mask;
    int          nbeats;
    int          resp_at;   // cycles after first ARP request cycle; -1 = never answer
    logic        resp_err;
    logic [47:0] resp_mac;
    logic        flush;
    logic        bp;
    logic [47:0] exp_mac;
    int          exp_arp;
    logic        exp_drop;
    logic        exp_fail;
    logic        exp_to;
    int          exp_dc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int pkt, input int i);
    return {16'hD0D0, 16'(pkt), 32'(i) ^ 32'h1234_5678};
  endfunction

  task automatic drive_beat(input int pkt, input int i, input int n);
    s_tdata = beat_data(pkt, i);
    s_tkeep = (i == n - 1) ? 8'h0F : 8'hFF;
    s_tlast = (i == n - 1);
    s_tuser = (i == 1);
  endtask

  task automatic run_pkt(input vec_t v, input int pkt);
    int cyc = 0, beat = 0, out_idx = 0, req_first = -1, resp_cyc = -1, hs_cyc = -1;
    int first_mv = -1, to_cyc = -1, n_req = 0, n_af = 0, n_to = 0, n_mv = 0;
    bit done = 0, hdr_taken, s_take;
    logic [47:0] got_mac = 'x, got_src = 'x;
    logic [31:0] got_dest = 'x;
    logic [KW-1:0] ek;
    local_ip = v.lip;
    subnet_mask = v.mask;
    if (v.flush) begin
      cache_flush = 1'b1;
      @(posedge clk); #1;
      cache_flush = 1'b0;
    end
    s_ip_dest_ip   = v.dest;
    s_ip_source_ip = v.lip;
    s_ip_length    = 16'(20 + 8 * v.nbeats);
    s_ip_hdr_valid = 1'b1;
    drive_beat(pkt, 0, v.nbeats);
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      hdr_taken = s_ip_hdr_valid && s_ip_hdr_ready;
      if (hdr_taken) hs_cyc = cyc;
      if (arp_request_valid && req_first < 0) req_first = cyc;
      if (arp_request_valid && arp_request_ready) n_req++;
      if (arp_response_valid && arp_response_ready) resp_cyc = cyc;
      if (m_ip_hdr_valid && first_mv < 0) first_mv = cyc;
      if (m_ip_hdr_valid && m_ip_hdr_ready) begin
        got_mac = m_eth_dest_mac;
        got_src = m_eth_src_mac;
        got_dest = m_ip_dest_ip;
      end
      if (tx_error_arp_failed) n_af++;
      if (tx_error_arp_timeout) begin n_to++; to_cyc = cyc; end
      if (m_tvalid) n_mv++;
      if (m_tvalid && m_tready) begin
        ek = (out_idx == v.nbeats - 1) ? 8'h0F : 8'hFF;
        check($sformatf("v%0d beat%0d", pkt, out_idx), {m_tdata, m_tkeep, m_tlast, m_tuser},
              {beat_data(pkt, out_idx), ek, 1'(out_idx == v.nbeats - 1), 1'(out_idx == 1)});
        out_idx++;
      end
      s_take = s_tvalid && s_tready;
      @(posedge clk); #1;
      cyc++;
      if (hdr_taken) s_ip_hdr_valid = 1'b0;
      if (s_take) begin
        if (beat == v.nbeats - 1) begin
          s_tvalid = 1'b0;
          done = 1;
        end else begin
          beat++;
          drive_beat(pkt, beat, v.nbeats);
        end
      end
      arp_response_valid = (v.resp_at >= 0) && (req_first >= 0) && (cyc == req_first + v.resp_at);
      arp_response_error = arp_response_valid && v.resp_err;
      arp_response_mac   = arp_response_valid ? v.resp_mac : 48'h0;
      m_tready = v.bp ? !m_tready : 1'b1;
    end
    arp_response_valid = 1'b0;
    arp_response_error = 1'b0;
    s_ip_hdr_valid = 1'b0;
    m_tready = 1'b1;
    check($sformatf("v%0d completed", pkt), 80'(done), 80'd1);
    @(negedge clk);
    check($sformatf("v%0d busy after", pkt), 80'(busy), 80'd0);
    check($sformatf("v%0d drop_count", pkt), 80'(drop_count), 80'(v.exp_dc));
    check($sformatf("v%0d arp requests", pkt), 80'(n_req), 80'(v.exp_arp));
    check($sformatf("v%0d arp_failed pulses", pkt), 80'(n_af), 80'(v.exp_fail));
    check($sformatf("v%0d arp_timeout pulses", pkt), 80'(n_to), 80'(v.exp_to));
    if (v.exp_drop) begin
      check($sformatf("v%0d m tvalid in drop", pkt), 80'(n_mv), 80'd0);
      check($sformatf("v%0d m hdr in drop", pkt), 80'(first_mv), 80'(-1));
    end else begin
      check($sformatf("v%0d dest mac", pkt), 80'(got_mac), 80'(v.exp_mac));
      check($sformatf("v%0d src mac", pkt), 80'(got_src), 80'(LMAC));
      check($sformatf("v%0d dest ip", pkt), 80'(got_dest), 80'(v.dest));
      check($sformatf("v%0d beats out", pkt), 80'(out_idx), 80'(v.nbeats));
      if (v.exp_arp == 0)
        check($sformatf("v%0d hdr latency", pkt), 80'(first_mv - hs_cyc), 80'd2);
      else
        check($sformatf("v%0d arp latency", pkt), 80'(first_mv - resp_cyc), 80'd1);
    end
    if (v.exp_to)
      check($sformatf("v%0d timeout cycle", pkt), 80'(to_cyc - req_first), 80'd16);
  endtask

  initial begin
    int k;
    bit seen, taken;
    vecs[0]  = '{32'hFFFF_FFFF, LIP, MSK, 2, -1, 1'b0, 48'h0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{32'hC0A8_01FF, LIP, MSK, 1, -1, 1'b0, 48'h0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{32'hEF81_0203, LIP, MSK, 2, -1, 1'b0, 48'h0, 1'b0, 1'b0, 48'h0100_5E01_0203, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{32'hE000_0001, LIP, MSK, 1, -1, 1'b0, 48'h0, 1'b0, 1'b0, 48'h0100_5E00_0001, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{32'hC0A8_010A, LIP, MSK, 3, 3, 1'b0, 48'h0200_0000_000A, 1'b0, 1'b0, 48'h0200_0000_000A, 1, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{32'hC0A8_010A, LIP, MSK, 3, -1, 1'b0, 48'h0, 1'b0, 1'b1, 48'h0200_0000_000A, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{32'hC0A8_010A, LIP, MSK, 3, 2, 1'b0, 48'h0200_0000_000A, 1'b1, 1'b0, 48'h0200_0000_000A, 1, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{32'hC0A8_0114, LIP, MSK, 4, 2, 1'b1, 48'h0, 1'b0, 1'b0, 48'h0, 1, 1'b1, 1'b1, 1'b0, 1};
    vecs[8]  = '{32'hC0A8_0115, LIP, MSK, 2, -1, 1'b0, 48'h0, 1'b0, 1'b0, 48'h0, 1, 1'b1, 1'b0, 1'b1, 2};
    vecs[9]  = '{32'hC0A8_0116, LIP, MSK, 2, 15, 1'b0, 48'h0200_0000_0016, 1'b0, 1'b0, 48'h0200_0000_0016, 1, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{32'hC0A8_0116, LIP, MSK, 2, -1, 1'b0, 48'h0, 1'b0, 1'b1, 48'h0200_0000_0016, 0, 1'b0, 1'b0, 1'b0, 2};

    rst = 1'b1;
    s_ip_hdr_valid = 1'b0; s_ip_dscp = 6'h2E; s_ip_ecn = 2'd1; s_ip_length = 16'd0;
    s_ip_ttl = 8'd64; s_ip_protocol = 8'd17; s_ip_source_ip = LIP; s_ip_dest_ip = 32'h0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_ip_hdr_ready = 1'b1; m_tready = 1'b1; arp_request_ready = 1'b1;
    arp_response_valid = 1'b0; arp_response_error = 1'b0; arp_response_mac = 48'h0;
    local_mac = LMAC; local_ip = LIP; subnet_mask = MSK; cache_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset hdr_ready", 80'(s_ip_hdr_ready), 80'd0);
    check("reset busy", 80'(busy), 80'd0);
    check("reset m_hdr_valid", 80'(m_ip_hdr_valid), 80'd0);
    check("reset arp_req", 80'(arp_request_valid), 80'd0);
    check("reset drop_count", 80'(drop_count), 80'd0);
    check("reset eth_type", 80'(m_eth_type), 80'h0800);
    check("reset dest_mac", 80'(m_eth_dest_mac), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle hdr_ready", 80'(s_ip_hdr_ready), 80'd1);

    for (int i = 0; i < 11; i++) run_pkt(vecs[i], i);

    // Reset in the middle of a forwarded broadcast packet.
    s_ip_dest_ip = 32'hFFFF_FFFF;
    s_ip_hdr_valid = 1'b1;
    drive_beat(99, 0, 4);
    s_tvalid = 1'b1;
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      taken = s_ip_hdr_valid && s_ip_hdr_ready;
      seen = m_tvalid;
      @(posedge clk); #1;
      if (taken) s_ip_hdr_valid = 1'b0;
      k++;
    end
    check("rst seq forwarding started", 80'(seen), 80'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst seq busy", 80'(busy), 80'd0);
    check("rst seq m tvalid", 80'(m_tvalid), 80'd0);
    check("rst seq drop_count", 80'(drop_count), 80'd0);
    s_tvalid = 1'b0;
    k = 0;
    while (!s_ip_hdr_ready && k < 2) begin
      @(posedge clk); #1;
      @(negedge clk);
      k++;
    end
    check("rst seq hdr_ready", 80'(s_ip_hdr_ready), 80'd1);
    check("rst seq s tready", 80'(s_tready), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
